dmem_port_arbiter: RTL and testbench
====================================

Name: dmem_port_arbiter

Overview:
- Shares the single synchronous data-memory port between two requesters: port 0 is the CPU load/store path and port 1 is the auxiliary master (debug loader / DMA).
- The CPU has fixed priority. A wait counter forces a grant to the aux port after it has been denied for a bounded number of cycles, so the aux port cannot starve.
- Sits between the datapath's memory stage and the DataMemory instance. Issues stall to the CPU when the CPU loses arbitration.

Parameters:
- DBITS, 32, data and address width.
- MEM_ADDR_BITS, 11, word-address width driven to the memory.
- AUX_MAX_WAIT, 8, consecutive denied aux cycles before a forced aux grant (legal range 1..255).
- IO_BIT, 31, address bit that marks the memory-mapped IO region; writes with this bit set are never forwarded to memory.

Ports:
- clk, in, 1, single clock; all state updates on posedge.
- reset, in, 1, asynchronous, active-low; the only reset.
- req0 / req1, in, 1, access request per port; held until granted.
- we0 / we1, in, 1, write (1) or read (0), valid with req.
- addr0 / addr1, in, DBITS, byte address.
- wdata0 / wdata1, in, DBITS, write data.
- gnt0 / gnt1, out, 1, combinational grant, same cycle as req.
- stall0, out, 1, req0 & ~gnt0; the CPU freezes its PC and pipeline registers.
- rvalid0 / rvalid1, out, 1, read data valid, exactly one cycle after a read grant.
- rdata0 / rdata1, out, DBITS, read data; zero when the matching rvalid is low.
- mem_addr, out, MEM_ADDR_BITS, addr[MEM_ADDR_BITS+1:2] of the granted port.
- mem_wdata, out, DBITS, wdata of the granted port.
- mem_we, out, 1, write strobe: granted & we & ~addr[IO_BIT].
- mem_rdata, in, DBITS, memory output, registered inside the memory (1-cycle latency).

Behaviour:
- Grant selection (combinational):
  - forced = req1 & (wait_cnt == AUX_MAX_WAIT).
  - gnt1 = req1 & (~req0 | forced).
  - gnt0 = req0 & ~gnt1.
  - At most one grant is high in any cycle.
- Wait counter (8 bits):
  - Reset to 0.
  - Increments when req1 & ~gnt1.
  - Clears to 0 when gnt1 or ~req1.
  - Saturates at AUX_MAX_WAIT and never wraps.
- With no grant, mem_we = 0 and mem_addr / mem_wdata = 0.
- Read tracking:
  - Registered rd_pend (1 bit) and rd_port (1 bit) capture "a read was granted" and its port each cycle.
  - Next cycle, rvalid of rd_port = rd_pend, and its rdata = mem_rdata.
  - The other port's rvalid and rdata are 0.
- Back-to-back reads from alternating ports return in grant order, one per cycle; no bubbles are inserted.
- IO-region access (addr[IO_BIT] = 1):
  - It is still granted, arbitrated and tracked.
  - mem_we is suppressed.
  - A read still produces rvalid; the IO read mux downstream overrides the data.
- Simultaneous req0 & req1 with the counter below the limit: port 0 wins and stall0 = 0.
- At the limit: port 1 wins, stall0 = 1 for exactly that cycle, and the counter clears.
- Reset asserted mid-operation:
  - wait_cnt = 0, rd_pend = 0.
  - All rvalid = 0 immediately (asynchronous).
  - A pending read is dropped and never returned.
- Reset values of registered outputs: rvalid0 = rvalid1 = 0 and rdata0 = rdata1 = 0. All other outputs are combinational from inputs and state.
- Latency: write takes effect at the grant edge. Read data is visible one cycle after the grant.

Optional Feature:
- DMEM_ARB_STATS_EN defined:
  - Adds outputs conflict_cnt[15:0] (cycles with req0 & req1) and forced_cnt[15:0] (forced aux grants).
  - Both reset to 0 and saturate at 16'hFFFF.
- Not defined: the ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - DBITS;
  - the IO address constants (F0000000 HEX, F0000004 LEDR, F0000008 LEDG, F0000010 KEY, F0000014 SW);
  - the port index constants PORT_CPU = 0 and PORT_AUX = 1.
- One natural sub-module: dmem_read_tracker, which holds rd_pend / rd_port and the rdata/rvalid steering.

Test Plan:
- Reset low for 3 cycles, then high: all rvalid = 0, gnt = 0, mem_we = 0, wait_cnt = 0.
- req0 write, addr 0x00000100, wdata 0xDEADBEEF: gnt0 = 1, mem_we = 1, mem_addr = 0x040. Then req0 read of 0x100: rvalid0 = 1 next cycle, rdata0 = 0xDEADBEEF, rvalid1 = 0.
- req0 and req1 held continuously, AUX_MAX_WAIT = 8: gnt1 = 1 on cycle 9 only, stall0 = 1 that cycle, then the 8-cycle wait pattern repeats.
- req1 write to 0xF0000004, wdata 0x3FF, no req0: gnt1 = 1, mem_we = 0.
- Alternating reads: port 0 reads 0x10, then port 1 reads 0x20 back to back. rvalid0 and rvalid1 are each high one cycle, in order, with correct data.
- Reset asserted the cycle after a read grant: rvalid stays 0 and no data is returned after reset releases.

Source files
------------

// File: rtl/dmem_port_arbiter_pkg.sv
// Shared constants for the data-memory port arbiter: data width,
// memory-mapped IO addresses and requester port indices.
package dmem_port_arbiter_pkg;

    localparam int DBITS = 32;

    localparam logic [31:0] IO_ADDR_HEX  = 32'hF000_0000;
    localparam logic [31:0] IO_ADDR_LEDR = 32'hF000_0004;
    localparam logic [31:0] IO_ADDR_LEDG = 32'hF000_0008;
    localparam logic [31:0] IO_ADDR_KEY  = 32'hF000_0010;
    localparam logic [31:0] IO_ADDR_SW   = 32'hF000_0014;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_AUX = 1'b1;

endpackage

// File: rtl/dmem_read_tracker.sv
// Remembers whether the previous cycle granted a read and to which port,
// then steers the memory's registered read data to that port only.
module dmem_read_tracker #(
    parameter int DBITS = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rd_gnt_i,
    input  logic             rd_port_i,
    input  logic [DBITS-1:0] mem_rdata_i,
    output logic             rvalid0_o,
    output logic             rvalid1_o,
    output logic [DBITS-1:0] rdata0_o,
    output logic [DBITS-1:0] rdata1_o
);
    import dmem_port_arbiter_pkg::*;

    logic rd_pend_q, rd_pend_d;
    logic rd_port_q, rd_port_d;

    // Next-state: capture this cycle's read grant and the port it belongs to.
    always_comb begin
        rd_pend_d = rd_gnt_i;
        rd_port_d = rd_gnt_i ? rd_port_i : rd_port_q;
    end

    // Pending-read registers; reset drops any read in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_pend_q <= 1'b0;
            rd_port_q <= PORT_CPU;
        end else begin
            rd_pend_q <= rd_pend_d;
            rd_port_q <= rd_port_d;
        end
    end

    // Route the returning data to the owning port; the other port sees zeros.
    always_comb begin
        rvalid0_o = 1'b0;
        rvalid1_o = 1'b0;
        rdata0_o  = '0;
        rdata1_o  = '0;
        if (rd_pend_q) begin
            if (rd_port_q == PORT_AUX) begin
                rvalid1_o = 1'b1;
                rdata1_o  = mem_rdata_i;
            end else begin
                rvalid0_o = 1'b1;
                rdata0_o  = mem_rdata_i;
            end
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter for the single synchronous data-memory port.
// Port 0 (CPU) has fixed priority; port 1 (aux/DMA) gets a forced grant
// once it has been denied AUX_MAX_WAIT consecutive cycles.
// Optional macro DMEM_ARB_STATS_EN adds conflict/forced-grant counters.
module dmem_port_arbiter #(
    parameter int DBITS         = dmem_port_arbiter_pkg::DBITS,
    parameter int MEM_ADDR_BITS = 11,
    parameter int AUX_MAX_WAIT  = 8,
    parameter int IO_BIT        = 31
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req0,
    input  logic                     we0,
    input  logic [DBITS-1:0]         addr0,
    input  logic [DBITS-1:0]         wdata0,
    input  logic                     req1,
    input  logic                     we1,
    input  logic [DBITS-1:0]         addr1,
    input  logic [DBITS-1:0]         wdata1,
    output logic                     gnt0,
    output logic                     gnt1,
    output logic                     stall0,
    output logic                     rvalid0,
    output logic                     rvalid1,
    output logic [DBITS-1:0]         rdata0,
    output logic [DBITS-1:0]         rdata1,
    output logic [MEM_ADDR_BITS-1:0] mem_addr,
    output logic [DBITS-1:0]         mem_wdata,
    output logic                     mem_we,
    input  logic [DBITS-1:0]         mem_rdata
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [15:0]              conflict_cnt,
    output logic [15:0]              forced_cnt
`endif
);
    import dmem_port_arbiter_pkg::*;

    localparam logic [7:0] AUX_MAX_WAIT_C = 8'(AUX_MAX_WAIT);

    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       forced;
    logic       rd_gnt;
    logic       rd_port;
    logic       unused_addr_bits;

    // Only the word-address field and IO_BIT of each address matter here.
    assign unused_addr_bits = ^{addr0, addr1};

    // Grant selection: CPU wins unless aux has waited out its budget.
    always_comb begin
        forced = req1 && (wait_cnt_q == AUX_MAX_WAIT_C);
        gnt1   = req1 && (!req0 || forced);
        gnt0   = req0 && !gnt1;
        stall0 = req0 && !gnt0;
    end

    // Memory-side mux; an idle port drives zeros so the bus is quiet.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        rd_gnt    = 1'b0;
        rd_port   = PORT_CPU;
        if (gnt1) begin
            mem_addr  = addr1[MEM_ADDR_BITS+1:2];
            mem_wdata = wdata1;
            mem_we    = we1 && !addr1[IO_BIT];
            rd_gnt    = !we1;
            rd_port   = PORT_AUX;
        end else if (gnt0) begin
            mem_addr  = addr0[MEM_ADDR_BITS+1:2];
            mem_wdata = wdata0;
            mem_we    = we0 && !addr0[IO_BIT];
            rd_gnt    = !we0;
            rd_port   = PORT_CPU;
        end
    end

    // Starvation counter: counts denied aux cycles, saturating at the limit.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!req1 || gnt1) begin
            wait_cnt_d = 8'd0;
        end else if (wait_cnt_q != AUX_MAX_WAIT_C) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end
    end

    // Wait counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt_q <= 8'd0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    dmem_read_tracker #(
        .DBITS(DBITS)
    ) u_read_tracker (
        .clk        (clk),
        .reset      (reset),
        .rd_gnt_i   (rd_gnt),
        .rd_port_i  (rd_port),
        .mem_rdata_i(mem_rdata),
        .rvalid0_o  (rvalid0),
        .rvalid1_o  (rvalid1),
        .rdata0_o   (rdata0),
        .rdata1_o   (rdata1)
    );

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] conflict_cnt_q, conflict_cnt_d;
    logic [15:0] forced_cnt_q, forced_cnt_d;

    // Saturating event counters for contention and forced aux grants.
    always_comb begin
        conflict_cnt_d = conflict_cnt_q;
        forced_cnt_d   = forced_cnt_q;
        if (req0 && req1 && (conflict_cnt_q != 16'hFFFF)) begin
            conflict_cnt_d = conflict_cnt_q + 16'd1;
        end
        if (forced && (forced_cnt_q != 16'hFFFF)) begin
            forced_cnt_d = forced_cnt_q + 16'd1;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            conflict_cnt_q <= 16'd0;
            forced_cnt_q   <= 16'd0;
        end else begin
            conflict_cnt_q <= conflict_cnt_d;
            forced_cnt_q   <= forced_cnt_d;
        end
    end

    assign conflict_cnt = conflict_cnt_q;
    assign forced_cnt   = forced_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
module tb_dmem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, we0, req1, we1;
    logic [31:0] addr0, wdata0, addr1, wdata1;
    logic        gnt0, gnt1, stall0, rvalid0, rvalid1;
    logic [31:0] rdata0, rdata1, mem_wdata, mem_rdata;
    logic [10:0] mem_addr;
    logic        mem_we;
`ifdef DMEM_ARB_STATS_EN
    logic [15:0] conflict_cnt, forced_cnt;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dmem_port_arbiter dut (
        .clk      (clk),
        .reset    (reset),
        .req0     (req0),
        .we0      (we0),
        .addr0    (addr0),
        .wdata0   (wdata0),
        .req1     (req1),
        .we1      (we1),
        .addr1    (addr1),
        .wdata1   (wdata1),
        .gnt0     (gnt0),
        .gnt1     (gnt1),
        .stall0   (stall0),
        .rvalid0  (rvalid0),
        .rvalid1  (rvalid1),
        .rdata0   (rdata0),
        .rdata1   (rdata1),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_we   (mem_we),
        .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_STATS_EN
        ,
        .conflict_cnt(conflict_cnt),
        .forced_cnt  (forced_cnt)
`endif
    );

    // Behavioural synchronous memory with one-cycle registered read.
    logic [31:0] mem    [0:2047];
    logic [31:0] shadow [0:2047];

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    typedef struct {
        logic        r0, w0;
        logic [31:0] a0, d0;
        logic        r1, w1;
        logic [31:0] a1, d1;
        logic        e_g0, e_g1, e_stall, e_we;
        logic [10:0] e_addr;
        logic [31:0] e_wdata;
    } vec_t;

    typedef struct {
        logic        port;
        logic [31:0] data;
    } rd_exp_t;

    rd_exp_t exp_q[$];

    function automatic vec_t mk(input logic r0, input logic w0, input logic [31:0] a0,
                                input logic [31:0] d0, input logic r1, input logic w1,
                                input logic [31:0] a1, input logic [31:0] d1,
                                input logic e_g0, input logic e_g1, input logic e_stall,
                                input logic e_we, input logic [10:0] e_addr,
                                input logic [31:0] e_wdata);
        vec_t v;
        v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
        v.e_g0 = e_g0; v.e_g1 = e_g1; v.e_stall = e_stall; v.e_we = e_we;
        v.e_addr = e_addr; v.e_wdata = e_wdata;
        return v;
    endfunction

    task automatic set_idle();
        req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
        req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
    endtask

    // Drive one vector at negedge, check combinational outputs, and record
    // the expected read return in the scoreboard.
    task automatic apply(input vec_t v, input string name);
        @(negedge clk);
        req0 = v.r0; we0 = v.w0; addr0 = v.a0; wdata0 = v.d0;
        req1 = v.r1; we1 = v.w1; addr1 = v.a1; wdata1 = v.d1;
        #1;
        n_cmp++;
        if ({gnt0, gnt1, stall0} !== {v.e_g0, v.e_g1, v.e_stall}) begin
            n_fail++;
            $display("FAIL %s grant: got g0=%b g1=%b stall0=%b, want g0=%b g1=%b stall0=%b",
                     name, gnt0, gnt1, stall0, v.e_g0, v.e_g1, v.e_stall);
        end
        n_cmp++;
        if ({mem_we, mem_addr, mem_wdata} !== {v.e_we, v.e_addr, v.e_wdata}) begin
            n_fail++;
            $display("FAIL %s membus: got we=%b addr=%h wdata=%h, want we=%b addr=%h wdata=%h",
                     name, mem_we, mem_addr, mem_wdata, v.e_we, v.e_addr, v.e_wdata);
        end
        if ((v.e_g0 && !v.w0) || (v.e_g1 && !v.w1)) begin
            rd_exp_t e;
            e.port = v.e_g1;
            e.data = shadow[v.e_addr];
            exp_q.push_back(e);
        end
        if (v.e_we) shadow[v.e_addr] = v.e_wdata;
    endtask

    // Read-return monitor: after every active edge the DUT must return
    // exactly the scoreboard head, or nothing when no read is outstanding.
    always @(posedge clk) begin
        logic        ev0, ev1;
        logic [31:0] ed0, ed1;
        #2;
        ev0 = 0; ev1 = 0; ed0 = 0; ed1 = 0;
        if (exp_q.size() > 0) begin
            rd_exp_t e;
            e = exp_q.pop_front();
            if (e.port) begin ev1 = 1; ed1 = e.data; end
            else        begin ev0 = 1; ed0 = e.data; end
        end
        n_cmp++;
        if ({rvalid0, rvalid1, rdata0, rdata1} !== {ev0, ev1, ed0, ed1}) begin
            n_fail++;
            $display("FAIL rdret @%0t: got rv0=%b rv1=%b rd0=%h rd1=%h, want rv0=%b rv1=%b rd0=%h rd1=%h",
                     $time, rvalid0, rvalid1, rdata0, rdata1, ev0, ev1, ed0, ed1);
        end
    end

    vec_t tbl[11];

    initial begin
        vec_t v;
        for (int i = 0; i < 2048; i++) begin
            mem[i]    = 32'hA500_0000 | 32'(i);
            shadow[i] = 32'hA500_0000 | 32'(i);
        end
        mem_rdata = 0;
        set_idle();

        //           r0 w0 a0            d0            r1 w1 a1            d1         g0 g1 st we addr     wdata
        tbl[0]  = mk(1, 1, 32'h0000_0100, 32'hDEAD_BEEF, 0, 0, 0,            0,         1, 0, 0, 1, 11'h040, 32'hDEAD_BEEF);
        tbl[1]  = mk(1, 0, 32'h0000_0100, 0,            0, 0, 0,            0,         1, 0, 0, 0, 11'h040, 0);
        tbl[2]  = mk(0, 0, 0,            0,            0, 0, 0,            0,         0, 0, 0, 0, 11'h000, 0);
        tbl[3]  = mk(0, 0, 0,            0,            1, 1, 32'hF000_0004, 32'h3FF,  0, 1, 0, 0, 11'h001, 32'h3FF);
        tbl[4]  = mk(1, 0, 32'h0000_0010, 0,            0, 0, 0,            0,         1, 0, 0, 0, 11'h004, 0);
        tbl[5]  = mk(0, 0, 0,            0,            1, 0, 32'h0000_0020, 0,         0, 1, 0, 0, 11'h008, 0);
        tbl[6]  = mk(1, 1, 32'h0000_0200, 32'h1111_1111, 1, 0, 32'h0000_0024, 0,       1, 0, 0, 1, 11'h080, 32'h1111_1111);
        tbl[7]  = mk(0, 0, 0,            0,            1, 0, 32'h0000_0024, 0,         0, 1, 0, 0, 11'h009, 0);
        tbl[8]  = mk(0, 0, 0,            0,            1, 0, 32'hF000_0010, 0,         0, 1, 0, 0, 11'h004, 0);
        tbl[9]  = mk(1, 1, 32'hF000_0014, 32'h5,       0, 0, 0,            0,         1, 0, 0, 0, 11'h005, 32'h5);
        tbl[10] = mk(1, 0, 32'h0000_0200, 0,            0, 0, 0,            0,         1, 0, 0, 0, 11'h080, 0);

        // Reset held for three cycles.
        reset = 0;
        repeat (3) @(negedge clk);
        reset = 1;
        apply(mk(0,0,0,0, 0,0,0,0, 0,0,0,0, 11'h000, 0), "post_reset");

        // Both ports held: aux forced on every 9th cycle, counter starts at 0.
        for (int i = 1; i <= 18; i++) begin
            logic g1;
            g1 = (i % 9 == 0);
            v = mk(1, 0, 32'h0000_0010, 0, 1, 0, 32'h0000_0020, 0,
                   !g1, g1, g1, 0, g1 ? 11'h008 : 11'h004, 0);
            apply(v, $sformatf("starve_c%0d", i));
        end
        apply(mk(0,0,0,0, 0,0,0,0, 0,0,0,0, 11'h000, 0), "starve_idle");

        for (int i = 0; i < 11; i++) apply(tbl[i], $sformatf("vec%0d", i));
        apply(mk(0,0,0,0, 0,0,0,0, 0,0,0,0, 11'h000, 0), "tbl_idle");

        // Reset lands right after a read grant: the read must never return.
        apply(mk(1, 0, 32'h0000_0100, 0, 0,0,0,0, 1,0,0,0, 11'h040, 0), "rst_read");
        @(posedge clk);
        #1;
        reset = 0;
        set_idle();
        exp_q.delete();
        #1;
        n_cmp++;
        if ({rvalid0, rvalid1} !== 2'b00) begin
            n_fail++;
            $display("FAIL rst_async_rvalid: got rv0=%b rv1=%b, want 0 0", rvalid0, rvalid1);
        end
        repeat (2) @(negedge clk);
        reset = 1;
        repeat (3) apply(mk(0,0,0,0, 0,0,0,0, 0,0,0,0, 11'h000, 0), "rst_after");

        @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d reads outstanding, want 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
